// File: rtl/mem_uart_tx.sv
// mem_uart_tx: streams a block of bytes out of memory onto an 8N1 serial line.
// Each byte is fetched through the shared memory mux, and the mux is held
// with tx_en for the whole block. After the fetch latency the byte is shifted
// out LSB first.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, waiting for start (ignored while done is pulsing)
// FETCH | tx_ad stable, waiting RD_LAT cycles for read data
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high), then one byte fewer remaining
// NEXT  | step address and fetch again, or finish the block
module mem_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int RD_LAT       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [14:0] base_ad,
  input  logic [14:0] length,
  input  logic [7:0]  TX_data,
  output logic        tx_en,
  output logic [14:0] tx_ad,
  output logic        tx_serial,
  output logic        busy,
  output logic        done
);

  // One shared down-counter times both the fetch wait and the bit periods.
  localparam int CNT_MAX = (CLKS_PER_BIT > RD_LAT) ? CLKS_PER_BIT : RD_LAT;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] BIT_LOAD   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FETCH_LOAD = CW'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, NEXT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [14:0]   ad_q, ad_d;
  logic [14:0]   rem_q, rem_d;
  logic          ser_q, ser_d;
  logic          done_q, done_d;

  // Register all FSM and datapath state; reset parks the line high in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ad_q    <= '0;
      rem_q   <= '0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ad_q    <= ad_d;
      rem_q   <= rem_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counters and the next value of the registered serial line.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ad_d    = ad_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    ser_d   = 1'b1;

    case (state_q)
      IDLE: begin
        // The done cycle is already IDLE, so gate on done_q to make a
        // start that coincides with the pulse count as ignored.
        if (start && !done_q) begin
          rem_d = length;
          if (length == 15'd0) begin
            state_d = NEXT;
          end else begin
            ad_d    = base_ad;
            cnt_d   = FETCH_LOAD;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (cnt_q == '0) begin
          shift_d = TX_data;
          cnt_d   = BIT_LOAD;
          state_d = START;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = BIT_LOAD;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          rem_d   = rem_q - 15'd1;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      NEXT: begin
        if (rem_q != 15'd0) begin
          ad_d    = ad_q + 15'd1;
          cnt_d   = FETCH_LOAD;
          state_d = FETCH;
        end else begin
          done_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so it is aligned with it.
    if (state_d == START)
      ser_d = 1'b0;
    else if (state_d == DATA)
      ser_d = shift_d[0];
  end

  assign busy      = (state_q != IDLE);
  assign tx_en     = busy;
  assign tx_ad     = ad_q;
  assign tx_serial = ser_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_uart_tx.sv
// tb_mem_uart_tx: directed bench for mem_uart_tx with CLKS_PER_BIT=4, RD_LAT=3.
module tb_mem_uart_tx;

  localparam int CPB = 4;
  localparam int RDL = 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] base_ad;
  logic [14:0] length;
  logic [7:0]  TX_data;
  logic        tx_en;
  logic [14:0] tx_ad;
  logic        tx_serial;
  logic        busy;
  logic        done;

  logic [7:0] mem [0:32767];
  logic [7:0] rd_p1;

  int cyc = 0;
  int low_cnt = 0;
  int done_cnt = 0;
  int en_cnt = 0;
  int checks = 0;
  int errors = 0;

  mem_uart_tx #(.CLKS_PER_BIT(CPB), .RD_LAT(RDL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_ad  (base_ad),
    .length   (length),
    .TX_data  (TX_data),
    .tx_en    (tx_en),
    .tx_ad    (tx_ad),
    .tx_serial(tx_serial),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data valid in the last of the RD_LAT fetch cycles.
  always @(posedge clk) begin
    rd_p1   <= mem[tx_ad];
    TX_data <= rd_p1;
    cyc     <= cyc + 1;
  end

  // Activity monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!tx_serial) low_cnt <= low_cnt + 1;
      if (done)       done_cnt <= done_cnt + 1;
      if (tx_en)      en_cnt <= en_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves us at the negedge of the cycle after start.
  task automatic do_start(input logic [14:0] b, input logic [14:0] l, output int t0);
    start   = 1'b1;
    base_ad = b;
    length  = l;
    t0      = cyc;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Waits for a start bit, then samples each bit in its middle.
  task automatic recv_frame(input string tag, output logic [7:0] b, output int lowc);
    bit found;
    found = 1'b0;
    b     = 8'h00;
    lowc  = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx_serial === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      check({tag, "_frame_timeout"}, 0, 1);
    end else begin
      lowc = cyc;
      for (int k = 1; k <= 9 * CPB + 2; k++) begin
        @(negedge clk);
        if (k % CPB == 2) begin
          if (k / CPB == 0)
            check({tag, "_start_bit"}, tx_serial, 0);
          else if (k / CPB == 9)
            check({tag, "_stop_bit"}, tx_serial, 1);
          else
            b[k / CPB - 1] = tx_serial;
        end
      end
    end
  endtask

  task automatic wait_done(input string tag, output int dc);
    bit found;
    found = 1'b0;
    dc    = 0;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) check({tag, "_done_timeout"}, 0, 1);
    else dc = cyc;
  endtask

  initial begin
    int t0, lc, lc2, dc, snap_low, snap_done, snap_en;
    logic [7:0] b;

    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    mem[15'h0010] = 8'h55;
    mem[15'h0020] = 8'hA1;
    mem[15'h0021] = 8'h00;
    mem[15'h0022] = 8'hFF;
    mem[15'h7FFF] = 8'h3C;
    mem[15'h0000] = 8'hC3;
    mem[15'h0100] = 8'h81;

    rst_n   = 1'b0;
    start   = 1'b0;
    base_ad = '0;
    length  = '0;
    repeat (3) @(negedge clk);
    check("rst_serial", tx_serial, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_done", done, 0);
    check("rst_tx_ad", tx_ad, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte 0x55 from 0x0010.
    snap_done = done_cnt;
    do_start(15'h0010, 15'd1, t0);
    check("t1_tx_ad", tx_ad, 15'h0010);
    check("t1_busy", busy, 1);
    check("t1_tx_en", tx_en, 1);
    recv_frame("t1", b, lc);
    check("t1_first_low", lc - t0, 4);
    check("t1_byte", b, 8'h55);
    wait_done("t1", dc);
    check("t1_start_to_done", dc - t0 + 1, 46);
    check("t1_busy_at_done", busy, 0);
    check("t1_en_at_done", tx_en, 0);
    @(negedge clk);
    check("t1_done_width", done, 0);
    check("t1_done_count", done_cnt - snap_done, 1);
    repeat (4) @(negedge clk);

    // Three bytes with inter-frame gap.
    do_start(15'h0020, 15'd3, t0);
    recv_frame("t2a", b, lc);
    check("t2a_byte", b, 8'hA1);
    check("t2a_tx_ad", tx_ad, 15'h0020);
    recv_frame("t2b", b, lc2);
    check("t2b_byte", b, 8'h00);
    check("t2b_tx_ad", tx_ad, 15'h0021);
    check("t2_gap", lc2 - lc, 10 * CPB + RDL + 1);
    recv_frame("t2c", b, lc);
    check("t2c_byte", b, 8'hFF);
    check("t2c_tx_ad", tx_ad, 15'h0022);
    wait_done("t2", dc);
    repeat (4) @(negedge clk);

    // Zero-length block.
    snap_low  = low_cnt;
    snap_en   = en_cnt;
    snap_done = done_cnt;
    do_start(15'h0123, 15'd0, t0);
    wait_done("t3", dc);
    check("t3_done_delay", dc - t0, 2);
    check("t3_busy_at_done", busy, 0);
    repeat (5) @(negedge clk);
    check("t3_no_low", low_cnt - snap_low, 0);
    check("t3_en_cycles", en_cnt - snap_en, 1);
    check("t3_done_count", done_cnt - snap_done, 1);

    // Address wrap.
    do_start(15'h7FFF, 15'd2, t0);
    recv_frame("t4a", b, lc);
    check("t4a_tx_ad", tx_ad, 15'h7FFF);
    check("t4a_byte", b, 8'h3C);
    recv_frame("t4b", b, lc);
    check("t4b_tx_ad", tx_ad, 15'h0000);
    check("t4b_byte", b, 8'hC3);
    wait_done("t4", dc);
    repeat (4) @(negedge clk);

    // start while busy, then start coincident with done.
    snap_low  = low_cnt;
    snap_done = done_cnt;
    do_start(15'h0100, 15'd1, t0);
    repeat (12) @(negedge clk);
    do_start(15'h0200, 15'd5, lc);
    wait_done("t5", dc);
    check("t5_tx_ad", tx_ad, 15'h0100);
    start   = 1'b1;
    base_ad = 15'h0020;
    length  = 15'd1;
    @(negedge clk);
    start   = 1'b0;
    check("t5_start_at_done_busy", busy, 0);
    repeat (60) @(negedge clk);
    check("t5_busy_after", busy, 0);
    check("t5_done_count", done_cnt - snap_done, 1);
    check("t5_low_cycles", low_cnt - snap_low, 7 * CPB);

    // Async reset during data bit 3 of 0x55.
    do_start(15'h0010, 15'd1, t0);
    repeat (20) @(negedge clk);
    check("t6_bit3_low", tx_serial, 0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_serial", tx_serial, 1);
    check("t6_rst_tx_en", tx_en, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_tx_ad", tx_ad, 0);
    @(negedge clk);
    rst_n = 1'b1;
    snap_low = low_cnt;
    repeat (60) @(negedge clk);
    check("t6_idle_busy", busy, 0);
    check("t6_no_resume", low_cnt - snap_low, 0);
    check("t6_line_high", tx_serial, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
